// File: rtl/nn_pkg.sv
// +----------------------------------------------------------------------------+
// | nn_pkg : shared widths and FSM encoding for nn_stream_driver               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package nn_pkg;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int ACC_W  = `ACC_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_FEED_IN  = 3'd2,
    ST_FEED_WT  = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_FIN      = 3'd5
  } drv_state_t;
endpackage

`default_nettype wire

// File: rtl/nn_stream_driver_if.sv
// +----------------------------------------------------------------------------+
// | nn_stream_driver_if : start pulse plus in/weight/result streams            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface nn_stream_driver_if;
  import nn_pkg::*;

  logic              acc_start;
  logic              acc_in_valid;
  logic [DATA_W-1:0] acc_in_data;
  logic              acc_in_ready;
  logic              acc_wt_valid;
  logic [DATA_W-1:0] acc_wt_data;
  logic              acc_wt_ready;
  logic              acc_out_valid;
  logic [ACC_W-1:0]  acc_out_data;
  logic              acc_out_ready;

  modport master (
    output acc_start,
    output acc_in_valid, acc_in_data,
    input  acc_in_ready,
    output acc_wt_valid, acc_wt_data,
    input  acc_wt_ready,
    input  acc_out_valid, acc_out_data,
    output acc_out_ready
  );

  modport slave (
    input  acc_start,
    input  acc_in_valid, acc_in_data,
    output acc_in_ready,
    input  acc_wt_valid, acc_wt_data,
    output acc_wt_ready,
    output acc_out_valid, acc_out_data,
    input  acc_out_ready
  );
endinterface

`default_nettype wire

// File: rtl/nn_drv_buf.sv
// +----------------------------------------------------------------------------+
// | nn_drv_buf : single-write, single-read buffer with registered read port    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module nn_drv_buf #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end
endmodule

`default_nettype wire

// File: rtl/nn_stream_driver.sv
// +----------------------------------------------------------------------------+
// | nn_stream_driver : host-side initiator feeding nn_accelerator streams      |
// | Optional stall timeout: NN_DRV_TIMEOUT_EN. Rev 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module nn_stream_driver
  import nn_pkg::*;
#(
  parameter int MAX_LEN        = 64,
  parameter int MAX_NEURONS    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           host_wr_en,
  input  logic                           host_wr_sel,
  input  logic [15:0]                    host_wr_addr,
  input  logic [DATA_W-1:0]              host_wr_data,
  input  logic [15:0]                    vector_len,
  input  logic [15:0]                    neuron_count,
  input  logic                           go,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  input  logic [$clog2(MAX_NEURONS)-1:0] res_rd_addr,
  output logic [ACC_W-1:0]               res_rd_data,
  nn_stream_driver_if.master             acc
);
  localparam int          IN_AW    = $clog2(MAX_LEN);
  localparam int          WT_DEPTH = MAX_LEN * MAX_NEURONS;
  localparam int          WT_AW    = $clog2(WT_DEPTH);
  localparam int          RES_AW   = $clog2(MAX_NEURONS);
  localparam logic [15:0] LEN_LIM  = 16'(MAX_LEN);
  localparam logic [15:0] CNT_LIM  = 16'(MAX_NEURONS);
  localparam logic [15:0] WT_LIM   = 16'(WT_DEPTH);

  drv_state_t  state, state_nxt;
  logic [15:0] len_q, cnt_q, i_q, i_nxt, j_q, j_nxt;
  logic        err_q, err_nxt;
  logic        cfg_ok, in_fire, wt_fire, out_fire, timeout_hit;
  logic [DATA_W-1:0] in_rdata, wt_rdata;

  assign busy              = state inside {ST_START, ST_FEED_IN, ST_FEED_WT, ST_WAIT_OUT};
  assign done              = (state == ST_FIN);
  assign err               = err_q;
  assign acc.acc_start     = (state == ST_START);
  assign acc.acc_in_valid  = (state == ST_FEED_IN);
  assign acc.acc_wt_valid  = (state == ST_FEED_WT);
  assign acc.acc_out_ready = (state == ST_WAIT_OUT);
  assign acc.acc_in_data   = in_rdata;
  assign acc.acc_wt_data   = wt_rdata;

  assign in_fire  = acc.acc_in_valid  && acc.acc_in_ready;
  assign wt_fire  = acc.acc_wt_valid  && acc.acc_wt_ready;
  assign out_fire = acc.acc_out_ready && acc.acc_out_valid;
  assign cfg_ok   = (vector_len != 16'd0) && (neuron_count != 16'd0) &&
                    (vector_len <= LEN_LIM) && (neuron_count <= CNT_LIM);

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    err_nxt   = err_q;
    case (state)
      ST_IDLE: begin
        i_nxt = '0;
        j_nxt = '0;
        if (go) begin
          state_nxt = cfg_ok ? ST_START : ST_FIN;
          err_nxt   = !cfg_ok;
        end
      end
      ST_START: state_nxt = ST_FEED_IN;
      ST_FEED_IN: begin
        if (in_fire) begin
          if (i_q == len_q - 16'd1) begin
            i_nxt     = '0;
            j_nxt     = '0;
            state_nxt = ST_FEED_WT;
          end else begin
            i_nxt = i_q + 16'd1;
          end
        end
      end
      ST_FEED_WT: begin
        if (wt_fire) begin
          if (i_q == len_q - 16'd1) begin
            i_nxt     = '0;
            state_nxt = ST_WAIT_OUT;
          end else begin
            i_nxt = i_q + 16'd1;
          end
        end
      end
      ST_WAIT_OUT: begin
        if (out_fire) begin
          if (j_q == cnt_q - 16'd1) begin
            state_nxt = ST_FIN;
          end else begin
            j_nxt     = j_q + 16'd1;
            i_nxt     = '0;
            state_nxt = ST_FEED_WT;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = ST_FIN;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      i_q   <= '0;
      j_q   <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      i_q   <= i_nxt;
      j_q   <= j_nxt;
      err_q <= err_nxt;
      if (state == ST_IDLE && go && cfg_ok) begin
        len_q <= vector_len;
        cnt_q <= neuron_count;
      end
    end
  end

`ifdef NN_DRV_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q;
  logic               stall_state;

  assign stall_state = state inside {ST_FEED_IN, ST_FEED_WT, ST_WAIT_OUT};
  assign timeout_hit = stall_state && !(in_fire || wt_fire || out_fire) &&
                       (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (!stall_state || in_fire || wt_fire || out_fire || state_nxt != state) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  // Read addresses follow the next-state indices so the data register already
  // holds the upcoming beat, and re-reads the same slot while stalled.
  nn_drv_buf #(.DEPTH(MAX_LEN), .WIDTH(DATA_W), .ADDR_W(IN_AW)) u_in_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (host_wr_en && !busy && !host_wr_sel && (host_wr_addr < LEN_LIM)),
    .wr_addr (IN_AW'(host_wr_addr)),
    .wr_data (host_wr_data),
    .rd_addr (IN_AW'(i_nxt)),
    .rd_data (in_rdata)
  );

  nn_drv_buf #(.DEPTH(WT_DEPTH), .WIDTH(DATA_W), .ADDR_W(WT_AW)) u_wt_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (host_wr_en && !busy && host_wr_sel && (host_wr_addr < WT_LIM)),
    .wr_addr (WT_AW'(host_wr_addr)),
    .wr_data (host_wr_data),
    .rd_addr (WT_AW'(j_nxt * LEN_LIM + i_nxt)),
    .rd_data (wt_rdata)
  );

  nn_drv_buf #(.DEPTH(MAX_NEURONS), .WIDTH(ACC_W), .ADDR_W(RES_AW)) u_res_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (out_fire),
    .wr_addr (RES_AW'(j_q)),
    .wr_data (acc.acc_out_data),
    .rd_addr (res_rd_addr),
    .rd_data (res_rd_data)
  );
endmodule

`default_nettype wire

// File: tb/tb_nn_stream_driver.sv
// +----------------------------------------------------------------------------+
// | tb_nn_stream_driver : scoreboard bench with a dot-product accelerator model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_nn_stream_driver;
  import nn_pkg::*;

  localparam int ML  = 64;
  localparam int MN  = 16;
  localparam int TO  = 16;
  localparam int RAW = $clog2(MN);

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              host_wr_en = 1'b0;
  logic              host_wr_sel = 1'b0;
  logic [15:0]       host_wr_addr = '0;
  logic [DATA_W-1:0] host_wr_data = '0;
  logic [15:0]       vector_len = '0;
  logic [15:0]       neuron_count = '0;
  logic              go = 1'b0;
  logic              busy, done, err;
  logic [RAW-1:0]    res_rd_addr = '0;
  logic [ACC_W-1:0]  res_rd_data;

  nn_stream_driver_if acc ();

  nn_stream_driver #(.MAX_LEN(ML), .MAX_NEURONS(MN), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .host_wr_en   (host_wr_en),
    .host_wr_sel  (host_wr_sel),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .vector_len   (vector_len),
    .neuron_count (neuron_count),
    .go           (go),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .res_rd_addr  (res_rd_addr),
    .res_rd_data  (res_rd_data),
    .acc          (acc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int starts, dones, in_beats, wt_beats, in_vcyc, wt_vcyc, out_rdy_cyc;
  int cur_len = 8;
  int ik, wk;
  longint sum;
  int in_vec [ML];
  bit bp = 1'b0;
  bit out_en = 1'b1;
  logic pend_in = 1'b0, pend_wt = 1'b0, prev_start = 1'b0, exp_e;
  logic [DATA_W-1:0] pend_in_data, pend_wt_data;
  logic [DATA_W-1:0] exp_in_q [$];
  logic [DATA_W-1:0] exp_wt_q [$];
  logic              exp_err_q [$];
  logic [ACC_W-1:0]  res_q [$];
  int exp_res [4] = '{204, 408, 612, 816};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Accelerator model plus scoreboard monitor; each negedge decides what
  // transfers on the following posedge.
  always @(negedge clk) begin
    if (!rstn) begin
      acc.acc_in_ready  = 1'b0;
      acc.acc_wt_ready  = 1'b0;
      acc.acc_out_valid = 1'b0;
      acc.acc_out_data  = '0;
      ik = 0; wk = 0; sum = 0;
      res_q.delete();
      pend_in = 1'b0; pend_wt = 1'b0; prev_start = 1'b0;
    end else begin
      acc.acc_in_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      acc.acc_wt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;

      if (prev_start) check("in_valid_after_start", {63'd0, acc.acc_in_valid}, 64'd1);
      prev_start = acc.acc_start;
      if (acc.acc_start) starts++;

      if (pend_in) check("in_hold", {47'd0, acc.acc_in_valid, acc.acc_in_data}, {47'd0, 1'b1, pend_in_data});
      if (pend_wt) check("wt_hold", {47'd0, acc.acc_wt_valid, acc.acc_wt_data}, {47'd0, 1'b1, pend_wt_data});

      if (acc.acc_in_valid) begin
        in_vcyc++;
        if (acc.acc_in_ready) begin
          in_beats++;
          if (exp_in_q.size() == 0) fail_now("in_extra_beat");
          else check("in_beat", 64'(acc.acc_in_data), 64'(exp_in_q.pop_front()));
          if (ik < ML) in_vec[ik] = int'(acc.acc_in_data);
          ik++;
        end
        pend_in      = !acc.acc_in_ready;
        pend_in_data = acc.acc_in_data;
      end else begin
        pend_in = 1'b0;
      end

      if (acc.acc_wt_valid) begin
        wt_vcyc++;
        if (acc.acc_wt_ready) begin
          wt_beats++;
          if (exp_wt_q.size() == 0) fail_now("wt_extra_beat");
          else check("wt_beat", 64'(acc.acc_wt_data), 64'(exp_wt_q.pop_front()));
          if (wk < ML) sum += longint'(in_vec[wk]) * longint'(acc.acc_wt_data);
          wk++;
          if (wk == cur_len) begin
            res_q.push_back(ACC_W'(sum));
            sum = 0;
            wk  = 0;
          end
        end
        pend_wt      = !acc.acc_wt_ready;
        pend_wt_data = acc.acc_wt_data;
      end else begin
        pend_wt = 1'b0;
      end

      acc.acc_out_valid = out_en && (res_q.size() != 0);
      acc.acc_out_data  = acc.acc_out_valid ? res_q[0] : '0;
      if (acc.acc_out_ready) out_rdy_cyc++;
      if (acc.acc_out_valid && acc.acc_out_ready) void'(res_q.pop_front());

      if (done) begin
        dones++;
        if (exp_err_q.size() == 0) begin
          fail_now("done_extra");
        end else begin
          exp_e = exp_err_q.pop_front();
          check("err_busy_at_done", {62'd0, err, busy}, {62'd0, exp_e, 1'b0});
        end
      end
    end
  end

  task automatic wr(input bit sel, input int addr, input int data);
    @(negedge clk);
    host_wr_en   = 1'b1;
    host_wr_sel  = sel;
    host_wr_addr = 16'(addr);
    host_wr_data = DATA_W'(data);
    @(posedge clk);
    #1 host_wr_en = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic run(input int len, input int cnt, input int rows, input bit e);
    cur_len = len; ik = 0; wk = 0; sum = 0;
    starts = 0; dones = 0; in_beats = 0; wt_beats = 0;
    in_vcyc = 0; wt_vcyc = 0; out_rdy_cyc = 0;
    if (rows > 0) begin
      for (int i = 0; i < len; i++) exp_in_q.push_back(DATA_W'(i + 1));
      for (int j = 0; j < rows; j++)
        for (int i = 0; i < len; i++) exp_wt_q.push_back(DATA_W'((j + 1) * (i + 1)));
    end
    exp_err_q.push_back(e);
    vector_len   = 16'(len);
    neuron_count = 16'(cnt);
    pulse_go();
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  task automatic rd_check(input int addr, input int exp, input string name);
    @(negedge clk);
    res_rd_addr = RAW'(addr);
    @(posedge clk);
    #1 check(name, 64'(res_rd_data), 64'(exp));
  endtask

  task automatic check_run(input string tag);
    for (int j = 0; j < 4; j++) rd_check(j, exp_res[j], {tag, "_result"});
    check({tag, "_starts"}, 64'(starts), 64'd1);
    check({tag, "_in_beats"}, 64'(in_beats), 64'd8);
    check({tag, "_wt_beats"}, 64'(wt_beats), 64'd32);
    check({tag, "_dones"}, 64'(dones), 64'd1);
    check({tag, "_queues_empty"}, 64'(exp_in_q.size() + exp_wt_q.size() + exp_err_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctrl"}, {57'd0, busy, done, err, acc.acc_start, acc.acc_in_valid,
                            acc.acc_wt_valid, acc.acc_out_ready}, 64'd0);
    check({name, "_data"}, {acc.acc_in_data, acc.acc_wt_data, res_rd_data}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_state");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) wr(1'b0, i, i + 1);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 8; i++) wr(1'b1, j * ML + i, (j + 1) * (i + 1));
    wr(1'b0, ML, 77);
    wr(1'b1, ML * MN, 77);

    // Basic run, ready always high
    run(8, 4, 4, 1'b0);
    wait_done(400, "basic_done");
    check_run("basic");

    // Backpressure on both input streams
    bp = 1'b1;
    run(8, 4, 4, 1'b0);
    wait_done(2000, "bp_done");
    check_run("bp");
    bp = 1'b0;

    // Illegal configurations
    run(0, 4, 0, 1'b1);
    wait_done(2, "illegal_len0_done");
    @(negedge clk);
    #1 check("illegal_len0_starts", 64'(starts), 64'd0);
    check("illegal_len0_valids", 64'(in_vcyc + wt_vcyc), 64'd0);
    check("illegal_len0_dones", 64'(dones), 64'd1);
    run(8, 17, 0, 1'b1);
    wait_done(2, "illegal_cnt17_done");
    repeat (3) @(negedge clk);
    #1 check("err_held", {63'd0, err}, 64'd1);
    check("illegal_cnt17_starts", 64'(starts), 64'd0);
    rd_check(0, 204, "res_keep_after_illegal");

    // go and host writes during a run are ignored
    run(8, 4, 4, 1'b0);
    repeat (15) @(posedge clk);
    wr(1'b0, 0, 99);
    wr(1'b1, 0, 99);
    pulse_go();
    wait_done(400, "busy_done");
    repeat (4) @(negedge clk);
    check_run("busy");
    run(8, 4, 4, 1'b0);
    wait_done(400, "rerun_done");
    check_run("rerun");

    // Asynchronous reset during FEED_WT of neuron 2
    run(8, 4, 4, 1'b0);
    begin
      int n = 0;
      while (wt_beats < 19 && n < 500) begin
        @(posedge clk);
        #1 n++;
      end
      check("reach_neuron2", {63'd0, (wt_beats >= 19)}, 64'd1);
    end
    #1 rstn = 1'b0;
    #1 check_outputs_zero("midrun_reset");
    exp_in_q.delete();
    exp_wt_q.delete();
    exp_err_q.delete();
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    run(8, 4, 4, 1'b0);
    wait_done(400, "after_reset_done");
    check_run("after_reset");

`ifdef NN_DRV_TIMEOUT_EN
    out_en = 1'b0;
    run(8, 4, 1, 1'b1);
    wait_done(200, "timeout_done");
    @(negedge clk);
    #1 check("timeout_stall_cycles", 64'(out_rdy_cyc), 64'd16);
    check("timeout_wt_beats", 64'(wt_beats), 64'd8);
    check("timeout_dones", 64'(dones), 64'd1);
    out_en = 1'b0;
    res_q.delete();
    out_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/nn_stream_driver.md
Name: nn_stream_driver

Overview:
Host-side initiator for nn_accelerator. It buffers one input vector and a weight matrix written by the host. On go, it pulses acc_start, streams the input vector, then for each neuron streams one weight row and captures that neuron's output word into a result buffer the host can read back.

Parameters:
MAX_LEN, 64, maximum vector_len; sets input buffer depth and weight row stride.
MAX_NEURONS, 16, maximum neuron_count; weight buffer depth is MAX_LEN*MAX_NEURONS, result buffer depth is MAX_NEURONS.
TIMEOUT_CYCLES, 1024, stall limit; used only with NN_DRV_TIMEOUT_EN.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
host_wr_en  in  1  buffer write strobe
host_wr_sel  in  1  write target: 0 = input buffer, 1 = weight buffer
host_wr_addr  in  16  input index, or weight index j*MAX_LEN+i
host_wr_data  in  `DATA_WIDTH  signed write data
vector_len  in  16  elements per vector; sampled on go
neuron_count  in  16  neurons to run; sampled on go
go  in  1  start-run pulse
busy  out  1  run in progress
done  out  1  one-cycle end-of-run pulse
err  out  1  status of last run; valid when done pulses; held until next go
res_rd_addr  in  $clog2(MAX_NEURONS)  result read index
res_rd_data  out  `ACC_WIDTH  result[res_rd_addr]; 1-cycle registered read
acc_start  out  1  start pulse to accelerator
acc_in_valid / acc_in_data / acc_in_ready  out / out / in  1 / `DATA_WIDTH / 1  input-vector stream
acc_wt_valid / acc_wt_data / acc_wt_ready  out / out / in  1 / `DATA_WIDTH / 1  weight stream
acc_out_valid / acc_out_data / acc_out_ready  in / in / out  1 / `ACC_WIDTH / 1  result stream

Behaviour:
- Reset values: busy, done, err, acc_start, all acc_*_valid, acc_out_ready = 0; data outputs = 0; FSM = IDLE. Buffer contents are not cleared.
- Stream handshake: a beat transfers on the clock edge where valid && ready. Valid and data are held stable until that transfer. Valid never depends combinationally on ready.
- Throughput: one beat per cycle while ready stays high, with no bubbles. Buffer read data is prefetched into the data register.
- FSM states: IDLE, START, FEED_IN, FEED_WT, WAIT_OUT, FIN.
  - IDLE: go sampled high with legal configuration → latch vector_len and neuron_count, clear err, go to START, busy=1.
  - Illegal configuration on go (vector_len=0, neuron_count=0, vector_len>MAX_LEN, or neuron_count>MAX_NEURONS) → FIN with err=1. No acc_start is issued.
  - START: acc_start=1 for exactly one cycle, then FEED_IN.
  - FEED_IN: acc_in_valid=1, data = in[i], i counts 0..vector_len-1. On the last transfer → FEED_WT with j=0, i=0. acc_in_valid is high on the cycle after acc_start.
  - FEED_WT: acc_wt_valid=1, data = w[j*MAX_LEN+i]. On the last transfer → WAIT_OUT.
  - WAIT_OUT: acc_out_ready=1. On an acc_out_valid transfer, result[j] ← acc_out_data and j++. If j = neuron_count-1 → FIN, else FEED_WT with i=0.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- acc_out_ready is 0 outside WAIT_OUT; acc_out_valid in any other state is not accepted.
- go while busy is ignored.
- Host writes: accepted only while busy=0. Writes while busy are dropped. Out-of-range addresses are dropped.
- res_rd_data is readable at any time. A result slot holds its previous value until overwritten by a run.
- Reset mid-run: immediate return to IDLE with every output at its reset value. The next go starts a full run from scratch.

Optional Feature:
NN_DRV_TIMEOUT_EN.
- Defined: a stall counter clears on every handshake and on each state change, and increments each cycle in FEED_IN, FEED_WT or WAIT_OUT without a transfer. On reaching TIMEOUT_CYCLES → FIN with err=1. All valids and acc_out_ready drop the same cycle FIN is entered.
- Undefined: no counter; the FSM waits indefinitely; err is raised only by an illegal configuration.

Decomposition:
- nn_pkg holds drv_state_t (the FSM enum) and shared width constants derived from `DATA_WIDTH / `ACC_WIDTH in defs.svh.
- One sub-module, nn_drv_buf: a single-write, single-read synchronous buffer parameterised by depth and width. It is instantiated three times: input, weight and result buffers.

Test Plan:
- Basic run: host writes in = 1..8 and w[j][i] = (j+1)(i+1); vector_len=8, neuron_count=4; model accelerator ready always high → results 204, 408, 612, 816; done pulses once; err=0; acc_start high for exactly 1 cycle.
- Backpressure: same data with acc_in_ready / acc_wt_ready toggled pseudo-randomly → identical results; beat counts exactly 8 and 32; data stable while valid && !ready.
- Illegal configuration: go with vector_len=0 → done within 2 cycles, err=1, no acc_start, no valids.
- go while busy, and host writes while busy → run unaffected; buffer contents unchanged after the run.
- Reset mid-run: rstn low during FEED_WT of neuron 2 → all outputs 0 immediately; a later go reproduces 204, 408, 612, 816.
- With NN_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=16: accelerator never asserts acc_out_valid → FIN after 16 stall cycles with err=1 and done pulse.
